// File: rtl/zdos_pkg.sv
// rtl/zdos_pkg.sv - shared types and constants for the DOS trap generator
package zdos_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILT     = 2'd1,
    DECIDE   = 2'd2,
    WAIT_END = 2'd3
  } state_t;

  localparam logic [7:0]  DOS_TRAP_PAGE = 8'h3D;
  localparam logic [15:0] NMI_VECTOR    = 16'h0066;
  localparam int          FILTER_W      = 3;

endpackage

// File: rtl/zdos_trap_if.sv
// rtl/zdos_trap_if.sv - Z80 bus view and DOS flag request lines for the trap generator
interface zdos_trap_if;

  logic        m1_n;
  logic        mreq_n;
  logic        rd_n;
  logic [15:0] za;
  logic        rom48;
  logic        dos;
  logic        nmi_req;
  logic        dos_turn_on;
  logic        dos_turn_off;

  modport master (
    output m1_n, mreq_n, rd_n, za, rom48, dos, nmi_req,
    input  dos_turn_on, dos_turn_off
  );

  modport slave (
    input  m1_n, mreq_n, rd_n, za, rom48, dos, nmi_req,
    output dos_turn_on, dos_turn_off
  );

endinterface

// File: rtl/zsync2.sv
// rtl/zsync2.sv - two-flop synchroniser with selectable reset value
module zsync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage capture of an asynchronous level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/zdos_trap.sv
// rtl/zdos_trap.sv - M1 fetch trap issuing DOS on/off requests; ZDOS_NMI_TRAP_EN adds the NMI vector trap
module zdos_trap
  import zdos_pkg::*;
#(
  parameter int FILTER = 2
) (
  input  logic       fclk,
  input  logic       rst,
  zdos_trap_if.slave bus
);

  if (FILTER < 1 || FILTER > 7) begin : g_filter_chk
    $error("zdos_trap: FILTER must be in 1..7");
  end

  localparam logic [FILTER_W-1:0] FILTER_C = FILTER_W'(FILTER);

  logic                m1_s, mreq_s, rd_s;
  logic                fetch;
  state_t              state_q, state_d;
  logic [FILTER_W-1:0] cnt;
  logic [15:0]         addr_q;
  logic [1:0]          primed;
  logic                nmi_hit;
  logic                on_hit, off_hit;
  logic                on_d, off_d;

  zsync2 #(.RST_VAL(1'b1)) u_sync_m1   (.clk(fclk), .rst(rst), .d(bus.m1_n),   .q(m1_s));
  zsync2 #(.RST_VAL(1'b1)) u_sync_mreq (.clk(fclk), .rst(rst), .d(bus.mreq_n), .q(mreq_s));
  zsync2 #(.RST_VAL(1'b1)) u_sync_rd   (.clk(fclk), .rst(rst), .d(bus.rd_n),   .q(rd_s));

  assign fetch = !m1_s && !mreq_s && !rd_s;

  // synchroniser outputs show their reset value, not the bus, for two edges after reset;
  // WAIT_END must not trust m1_s until the real level has propagated through
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) primed <= 2'b00;
    else     primed <= {primed[0], 1'b1};
  end

  // state register; reset parks in WAIT_END so an in-flight M1 cannot trigger
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) state_q <= WAIT_END;
    else     state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (fetch) state_d = FILT;
      FILT:     if (!fetch) state_d = IDLE;
                else if (cnt == FILTER_C) state_d = DECIDE;
      DECIDE:   state_d = WAIT_END;
      WAIT_END: if (primed[1] && m1_s) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // filter counter and fetch address capture
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      addr_q <= '0;
    end else if (state_q == IDLE && fetch) begin
      cnt <= FILTER_W'(1);
    end else if (state_q == FILT && fetch) begin
      if (cnt == FILTER_C) addr_q <= bus.za;
      else                 cnt    <= cnt + FILTER_W'(1);
    end
  end

`ifdef ZDOS_NMI_TRAP_EN
  logic nmi_arm;

  // sticky arm from the magic button; a new request beats the clearing fetch
  always_ff @(posedge fclk or posedge rst) begin
    if (rst)                                           nmi_arm <= 1'b0;
    else if (bus.nmi_req)                              nmi_arm <= 1'b1;
    else if (state_q == DECIDE && addr_q == NMI_VECTOR) nmi_arm <= 1'b0;
  end

  assign nmi_hit = nmi_arm && (addr_q == NMI_VECTOR) && !bus.dos;
`else
  logic unused_nmi;
  assign unused_nmi = ^{bus.nmi_req, addr_q[7:0]};
  assign nmi_hit    = 1'b0;
`endif

  // hit decode, only meaningful in the single DECIDE cycle
  always_comb begin
    on_hit  = ((addr_q[15:8] == DOS_TRAP_PAGE) && bus.rom48 && !bus.dos) || nmi_hit;
    off_hit = (addr_q[15:14] != 2'b00) && bus.dos;
    on_d    = (state_q == DECIDE) && on_hit;
    off_d   = (state_q == DECIDE) && off_hit;
  end

  // registered one-cycle request pulses
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      bus.dos_turn_on  <= 1'b0;
      bus.dos_turn_off <= 1'b0;
    end else begin
      bus.dos_turn_on  <= on_d;
      bus.dos_turn_off <= off_d;
    end
  end

endmodule

// File: tb/tb_zdos_trap.sv
// tb/tb_zdos_trap.sv - directed scoreboard bench for zdos_trap
module tb_zdos_trap;

  localparam int FILTER = 2;
`ifdef ZDOS_NMI_TRAP_EN
  localparam logic [1:0] NMI_KIND = 2'b10;
`else
  localparam logic [1:0] NMI_KIND = 2'b00;
`endif

  typedef struct {
    logic [1:0] kind;
    int         at;
  } ev_t;

  logic fclk = 1'b0;
  logic rst  = 1'b1;
  int   cyc  = 0;
  int   total = 0;
  int   bad   = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  zdos_trap_if bus();

  zdos_trap #(.FILTER(FILTER)) dut (
    .fclk (fclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 fclk = ~fclk;

  always @(posedge fclk) cyc <= cyc + 1;

  // record every request pulse with the cycle it was seen in; {on,off}
  always @(negedge fclk) begin
    if (bus.dos_turn_on || bus.dos_turn_off)
      obs_q.push_back('{kind: {bus.dos_turn_on, bus.dos_turn_off}, at: cyc});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    ev_t e;
    ev_t o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      else begin
        o.kind = 2'b00;
        o.at   = -1;
      end
      chk({tag, "_kind"}, 32'(o.kind), 32'(e.kind));
      chk({tag, "_cycle"}, o.at, e.at);
    end
    chk({tag, "_extra"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  task automatic set_flags(input logic r, input logic d);
    @(negedge fclk);
    bus.rom48 = r;
    bus.dos   = d;
  endtask

  task automatic release_bus();
    @(negedge fclk);
    bus.m1_n   = 1'b1;
    bus.mreq_n = 1'b1;
    bus.rd_n   = 1'b1;
  endtask

  // one bus read; hold = number of rising edges that sample the strobes low
  task automatic fetch(input logic [15:0] a, input logic is_m1, input int hold, input logic [1:0] kind);
    int t0;
    @(negedge fclk);
    bus.za     = a;
    bus.m1_n   = !is_m1;
    bus.mreq_n = 1'b0;
    bus.rd_n   = 1'b0;
    @(posedge fclk);
    #1 t0 = cyc;
    if (kind != 2'b00) exp_q.push_back('{kind: kind, at: t0 + FILTER + 3});
    repeat (hold - 1) @(posedge fclk);
    release_bus();
    repeat (12) @(posedge fclk);
  endtask

  initial begin
    int t0;
    bus.m1_n    = 1'b0;
    bus.mreq_n  = 1'b0;
    bus.rd_n    = 1'b0;
    bus.za      = 16'h3D2F;
    bus.rom48   = 1'b1;
    bus.dos     = 1'b0;
    bus.nmi_req = 1'b0;

    // reset with an M1 already in progress
    repeat (3) @(posedge fclk);
    #1;
    chk("reset_on", 32'(bus.dos_turn_on), 0);
    chk("reset_off", 32'(bus.dos_turn_off), 0);
    @(negedge fclk) rst = 1'b0;
    repeat (12) @(posedge fclk);
    drain("rst_during_m1");
    release_bus();
    repeat (4) @(posedge fclk);

    // DOS entry and its gating
    fetch(16'h3D2F, 1'b1, 10, 2'b10);
    drain("entry");
    set_flags(1'b0, 1'b0);
    fetch(16'h3D2F, 1'b1, 10, 2'b00);
    drain("entry_no_rom48");
    set_flags(1'b1, 1'b1);
    fetch(16'h3D2F, 1'b1, 10, 2'b00);
    drain("entry_dos_set");
    set_flags(1'b1, 1'b0);
    fetch(16'h3CFF, 1'b1, 10, 2'b00);
    drain("entry_3cff");
    fetch(16'h3E00, 1'b1, 10, 2'b00);
    drain("entry_3e00");
    fetch(16'h3D00, 1'b1, 10, 2'b10);
    drain("entry_3d00");

    // DOS exit
    set_flags(1'b0, 1'b1);
    fetch(16'h8000, 1'b1, 10, 2'b01);
    drain("exit_8000");
    fetch(16'h3FFF, 1'b1, 10, 2'b00);
    drain("exit_3fff");
    fetch(16'h4000, 1'b1, 10, 2'b01);
    drain("exit_4000");
    set_flags(1'b0, 1'b0);
    fetch(16'h8000, 1'b1, 10, 2'b00);
    drain("exit_dos_clear");

    // glitch filter and non-M1 read
    set_flags(1'b1, 1'b0);
    fetch(16'h3D2F, 1'b1, 1, 2'b00);
    drain("glitch");
    fetch(16'h3D2F, 1'b1, 3, 2'b10);
    drain("filter_min_hold");
    set_flags(1'b0, 1'b1);
    fetch(16'h8000, 1'b0, 10, 2'b00);
    drain("non_m1_read");

    // second qualifier inside one M1 low period
    set_flags(1'b1, 1'b0);
    @(negedge fclk);
    bus.za     = 16'h3D2F;
    bus.m1_n   = 1'b0;
    bus.mreq_n = 1'b0;
    bus.rd_n   = 1'b0;
    @(posedge fclk);
    #1 t0 = cyc;
    exp_q.push_back('{kind: 2'b10, at: t0 + FILTER + 3});
    repeat (9) @(posedge fclk);
    @(negedge fclk);
    bus.mreq_n = 1'b1;
    bus.rd_n   = 1'b1;
    repeat (3) @(posedge fclk);
    @(negedge fclk);
    bus.mreq_n = 1'b0;
    bus.rd_n   = 1'b0;
    repeat (10) @(posedge fclk);
    release_bus();
    repeat (12) @(posedge fclk);
    drain("one_per_m1");

    // reset while the request pulse is high
    @(negedge fclk);
    bus.za     = 16'h3D2F;
    bus.m1_n   = 1'b0;
    bus.mreq_n = 1'b0;
    bus.rd_n   = 1'b0;
    @(posedge fclk);
    repeat (FILTER + 3) @(posedge fclk);
    #1 chk("pulse_before_rst", 32'(bus.dos_turn_on), 1);
    #1 rst = 1'b1;
    #1 chk("async_rst_clears", 32'(bus.dos_turn_on), 0);
    @(negedge fclk) rst = 1'b0;
    repeat (6) @(posedge fclk);
    release_bus();
    repeat (12) @(posedge fclk);
    drain("rst_mid_op");

    // NMI vector trap
    set_flags(1'b0, 1'b0);
    @(negedge fclk) bus.nmi_req = 1'b1;
    @(negedge fclk) bus.nmi_req = 1'b0;
    fetch(16'h0066, 1'b1, 10, NMI_KIND);
    drain("nmi_first");
    fetch(16'h0066, 1'b1, 10, 2'b00);
    drain("nmi_second");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
